// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : MEM/WB pipeline register and write-back stage. Latches the
//             MEM-stage result bundle, selects the write-back value (ALU
//             result, load data or link address), drives the register file
//             write port, provides a same-cycle write-through bypass for the
//             ID-stage operand reads and counts retired instructions.
//  Ports    : clk, rst (async, active-high)
//             in_*                 - MEM-stage result bundle
//             stall / flush        - hold / insert bubble (flush wins)
//             reg1/2_addr, data1/2 - ID read addresses and raw RF data
//             write_bus/addr/en    - register file write port
//             fwd_data1/2          - bypass-corrected ID operands
//             retired              - count of instructions leaving the stage
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
   parameter int word_len = 32,
   parameter int addr_len = 5,
   parameter int link_reg = 31
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_reg_write,
   input  logic                in_mem_to_reg,
   input  logic                in_link,
   input  logic [word_len-1:0] in_alu_result,
   input  logic [word_len-1:0] in_mem_rdata,
   input  logic [word_len-1:0] in_pc_plus4,
   input  logic [addr_len-1:0] in_rd_addr,
   input  logic                stall,
   input  logic                flush,
   input  logic [addr_len-1:0] reg1_addr,
   input  logic [addr_len-1:0] reg2_addr,
   input  logic [word_len-1:0] data1,
   input  logic [word_len-1:0] data2,
   output logic [word_len-1:0] write_bus,
   output logic [addr_len-1:0] write_addr,
   output logic                write_en,
   output logic [word_len-1:0] fwd_data1,
   output logic [word_len-1:0] fwd_data2,
   output logic [31:0]         retired
);

   localparam logic [addr_len-1:0] c_link_addr = addr_len'(link_reg);
   localparam logic [addr_len-1:0] c_zero_addr = '0;

   logic                r_valid;
   logic                r_reg_write;
   logic                r_mem_to_reg;
   logic                r_link;
   logic [word_len-1:0] r_alu_result;
   logic [word_len-1:0] r_mem_rdata;
   logic [word_len-1:0] r_pc_plus4;
   logic [addr_len-1:0] r_rd_addr;
   logic [31:0]         r_retired;

   logic [word_len-1:0] w_write_bus;
   logic [addr_len-1:0] w_write_addr;
   logic                w_write_en;
   logic                w_leaving;

   // The held instruction leaves when the stage advances or is flushed; a
   // stalled instruction is therefore counted exactly once, on release.
   assign w_leaving = r_valid & (~stall | flush);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_link       <= 1'b0;
         r_alu_result <= '0;
         r_mem_rdata  <= '0;
         r_pc_plus4   <= '0;
         r_rd_addr    <= '0;
         r_retired    <= '0;
      end else begin
         if (w_leaving) begin
            r_retired <= r_retired + 32'd1;
         end
         if (flush) begin
            // Only the control bits matter for a bubble; data fields hold.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
         end else if (!stall) begin
            r_valid      <= in_valid;
            r_reg_write  <= in_reg_write;
            r_mem_to_reg <= in_mem_to_reg;
            r_link       <= in_link;
            r_alu_result <= in_alu_result;
            r_mem_rdata  <= in_mem_rdata;
            r_pc_plus4   <= in_pc_plus4;
            r_rd_addr    <= in_rd_addr;
         end
      end
   end

   // Write-back select: link overrides the load path and the destination.
   always_comb begin
      w_write_bus  = r_alu_result;
      w_write_addr = r_rd_addr;
      if (r_link) begin
         w_write_bus  = r_pc_plus4;
         w_write_addr = c_link_addr;
      end else if (r_mem_to_reg) begin
         w_write_bus  = r_mem_rdata;
      end
   end

   // Register 0 is hard-wired; suppressing its write also stops it from
   // ever being bypassed.
   assign w_write_en = r_valid & r_reg_write & (w_write_addr != c_zero_addr);

   always_comb begin
      fwd_data1 = data1;
      fwd_data2 = data2;
      if (w_write_en && (w_write_addr == reg1_addr)) begin
         fwd_data1 = w_write_bus;
      end
      if (w_write_en && (w_write_addr == reg2_addr)) begin
         fwd_data2 = w_write_bus;
      end
   end

   assign write_bus  = w_write_bus;
   assign write_addr = w_write_addr;
   assign write_en   = w_write_en;
   assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Self-checking bench for mem_wb_stage. Expected write-port and
//             counter values are queued when a bundle is driven and compared
//             one edge later when the stage presents it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_reg_write = 1'b0, in_mem_to_reg = 1'b0, in_link = 1'b0;
   logic [31:0] in_alu_result = '0, in_mem_rdata = '0, in_pc_plus4 = '0;
   logic [4:0]  in_rd_addr = '0;
   logic        stall = 1'b0, flush = 1'b0;
   logic [4:0]  reg1_addr = '0, reg2_addr = '0;
   logic [31:0] data1 = '0, data2 = '0;
   logic [31:0] write_bus;
   logic [4:0]  write_addr;
   logic        write_en;
   logic [31:0] fwd_data1, fwd_data2;
   logic [31:0] retired;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] bus;
      logic [31:0] ret;
      logic        care;   // addr/bus meaningful (not after a flush)
   } exp_t;

   exp_t sb[$];
   exp_t last;
   logic m_valid;

   mem_wb_stage dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_reg_write  (in_reg_write),
      .in_mem_to_reg (in_mem_to_reg),
      .in_link       (in_link),
      .in_alu_result (in_alu_result),
      .in_mem_rdata  (in_mem_rdata),
      .in_pc_plus4   (in_pc_plus4),
      .in_rd_addr    (in_rd_addr),
      .stall         (stall),
      .flush         (flush),
      .reg1_addr     (reg1_addr),
      .reg2_addr     (reg2_addr),
      .data1         (data1),
      .data2         (data2),
      .write_bus     (write_bus),
      .write_addr    (write_addr),
      .write_en      (write_en),
      .fwd_data1     (fwd_data1),
      .fwd_data2     (fwd_data2),
      .retired       (retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                        input logic [31:0] alu, input logic [31:0] rd_data,
                        input logic [31:0] pc4, input logic [4:0] rd,
                        input logic st, input logic fl);
      in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_link = lnk;
      in_alu_result = alu; in_mem_rdata = rd_data; in_pc_plus4 = pc4;
      in_rd_addr = rd; stall = st; flush = fl;
   endtask

   task automatic model_reset();
      last = '{en: 1'b0, addr: 5'd0, bus: 32'd0, ret: 32'd0, care: 1'b1};
      m_valid = 1'b0;
      sb.delete();
   endtask

   // Queue the expectation implied by the current inputs, clock once, then
   // pop and compare against what the stage now presents.
   task automatic tick(input string tag);
      exp_t e;
      exp_t got;
      logic [4:0] dest;
      e = last;
      if (flush) begin
         e.en = 1'b0;
         e.care = 1'b0;
      end else if (!stall) begin
         dest   = in_link ? 5'd31 : in_rd_addr;
         e.addr = dest;
         e.bus  = in_link ? in_pc_plus4 : (in_mem_to_reg ? in_mem_rdata : in_alu_result);
         e.en   = in_valid && in_reg_write && (dest != 5'd0);
         e.care = 1'b1;
      end
      e.ret = last.ret + ((m_valid && (!stall || flush)) ? 32'd1 : 32'd0);
      if (flush)       m_valid = 1'b0;
      else if (!stall) m_valid = in_valid;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({tag, ".en"}, {31'd0, write_en}, {31'd0, got.en});
      chk({tag, ".ret"}, retired, got.ret);
      if (got.care) begin
         chk({tag, ".addr"}, {27'd0, write_addr}, {27'd0, got.addr});
         chk({tag, ".bus"}, write_bus, got.bus);
      end
      last = got;
   endtask

   initial begin
      model_reset();
      data1 = 32'hAAAA_0001; data2 = 32'hBBBB_0002;
      #3;
      chk("rst.en", {31'd0, write_en}, 32'd0);
      chk("rst.bus", write_bus, 32'd0);
      chk("rst.addr", {27'd0, write_addr}, 32'd0);
      chk("rst.ret", retired, 32'd0);
      chk("rst.fwd1", fwd_data1, 32'hAAAA_0001);
      chk("rst.fwd2", fwd_data2, 32'hBBBB_0002);
      @(negedge clk);
      rst = 1'b0;

      // ALU write, then load, then link (link forces r31)
      drive(1, 1, 0, 0, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 0);          tick("alu");
      drive(1, 1, 1, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 5'd8, 0, 0);    tick("load");
      drive(1, 1, 1, 1, 32'h10, 32'hDEAD_BEEF, 32'h40, 5'd8, 0, 0);   tick("link");

      // Write to r0 is suppressed and never bypasses
      drive(1, 1, 0, 0, 32'h99, 32'h0, 32'h0, 5'd0, 0, 0);            tick("r0");
      reg1_addr = 5'd0; data1 = 32'd0; reg2_addr = 5'd0; data2 = 32'h77;
      #1;
      chk("r0.fwd1", fwd_data1, 32'd0);
      chk("r0.fwd2", fwd_data2, 32'h77);

      // Bypass of pending write r7 = 0x55
      drive(1, 1, 0, 0, 32'h55, 32'h0, 32'h0, 5'd7, 0, 0);            tick("byp");
      reg1_addr = 5'd7; data1 = 32'h11; reg2_addr = 5'd3; data2 = 32'h22;
      #1;
      chk("byp.fwd1", fwd_data1, 32'h55);
      chk("byp.fwd2", fwd_data2, 32'h22);
      reg2_addr = 5'd7;
      #1;
      chk("byp.fwd2hit", fwd_data2, 32'h55);

      // Stall three cycles with garbage inputs: r7 write held, no count
      drive(1, 1, 1, 1, 32'hBAD0, 32'hBAD1, 32'hBAD2, 5'd9, 1, 0);
      tick("stall1"); tick("stall2"); tick("stall3");
      drive(1, 1, 0, 0, 32'hA, 32'h0, 32'h0, 5'd9, 0, 0);             tick("release");

      // Stall and flush together: bubble, held instruction still counted
      drive(1, 1, 0, 0, 32'hB, 32'h0, 32'h0, 5'd10, 1, 1);            tick("stflush");
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 1, 0);             tick("bubble_stall");
      drive(1, 1, 0, 0, 32'hC, 32'h0, 32'h0, 5'd11, 0, 0);            tick("after_flush");

      // Asynchronous reset between edges drops the pending write at once
      #2;
      rst = 1'b1;
      #1;
      chk("arst.en", {31'd0, write_en}, 32'd0);
      chk("arst.ret", retired, 32'd0);
      chk("arst.bus", write_bus, 32'd0);
      model_reset();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 1, 0, 0, 32'h77, 32'h0, 32'h0, 5'd4, 0, 0);            tick("post_rst");

      // Counter wrap: preload to all-ones while a valid instruction is held
      force dut.r_retired = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired;
      #1;
      chk("wrap.pre", retired, 32'hFFFF_FFFF);
      last.ret = 32'hFFFF_FFFF;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);             tick("wrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
